// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared FSM state encoding and requester IDs for the
// two-port ROM read arbiter.
package rom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage : rom_arbiter_pkg

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: combinational grant selection between two ROM requesters.
// Build option ROM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie and
// last_owner is ignored; otherwise a tie goes to whoever was not served last.
module rom_arb_pick
    import rom_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

`ifdef ROM_ARB_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Fixed priority: requester 0 wins whenever it is asking.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req0 ? OWNER_M0 : OWNER_M1;
    end
`else
    // Round-robin: a tie goes to the requester that was not served last.
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end else begin
            grant_id = req0 ? OWNER_M0 : OWNER_M1;
        end
    end
`endif

endmodule : rom_arb_pick

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM between an instruction-fetch
// requester (m0) and a bus-slave requester (m1). Each read is
// IDLE/DATA -> ISSUE -> DATA; the data phase re-arbitrates over the live
// requests so a requester that keeps req high gets one word every 2 cycles.
// Build option ROM_ARB_FIXED_PRIO_EN selects fixed priority (m0 first)
// instead of round-robin inside rom_arb_pick.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_rdy,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_rdy,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_douta,
    output logic              busy
);

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              last_owner_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              grant_valid;
    logic              grant_id;
    logic              grant_en;

    rom_arb_pick u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grants are taken only from IDLE or from the data phase.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = DATA;
            end
            DATA: begin
                if (grant_valid) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant capture: address, owner and round-robin history change only on a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_q   <= '0;
            owner_q      <= OWNER_M0;
            last_owner_q <= OWNER_M1;
        end else if (grant_en) begin
            rom_addr_q   <= (grant_id == OWNER_M1) ? m1_addr : m0_addr;
            owner_q      <= grant_id;
            last_owner_q <= grant_id;
        end
    end

    // Outputs: ROM data passes straight through to the owner during DATA only.
    always_comb begin
        m0_rdy  = 1'b0;
        m1_rdy  = 1'b0;
        rd_data = '0;
        busy    = (state_q != IDLE);
        if (state_q == DATA) begin
            rd_data = rom_douta;
            m0_rdy  = (owner_q == OWNER_M0);
            m1_rdy  = (owner_q == OWNER_M1);
        end
    end

    assign rom_addr = rom_addr_q;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a
// one-cycle synchronous ROM model. Inputs change 1 ns after a rising edge;
// outputs are sampled at that same point, well away from the next edge.
module tb_rom_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              m0_req = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic              m0_rdy;
    logic              m1_req = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic              m1_rdy;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_douta = '0;
    logic              busy;

    logic [DATA_W-1:0] mem [0:2047];

    int checks = 0;
    int errors = 0;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_rdy    (m0_rdy),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_rdy    (m1_rdy),
        .rd_data   (rd_data),
        .rom_addr  (rom_addr),
        .rom_douta (rom_douta),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the sampled address appears after the edge.
    always @(posedge clk) rom_douta <= mem[rom_addr];

    // Continuous properties: exclusive rdy, rom_addr moves only into ISSUE.
    logic [ADDR_W-1:0] prev_addr = '0;
    logic              prev_ok = 1'b0;
    always @(negedge clk) begin
        checks++;
        if (m0_rdy && m1_rdy) begin
            errors++;
            $display("FAIL rdy_exclusive at %0t: m0_rdy=%b m1_rdy=%b want not both", $time, m0_rdy, m1_rdy);
        end
        if (!reset) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && (rom_addr != prev_addr)) begin
                checks++;
                if (!(busy && !m0_rdy && !m1_rdy)) begin
                    errors++;
                    $display("FAIL rom_addr_change at %0t: addr %h->%h outside a grant (busy=%b)", $time, prev_addr, rom_addr, busy);
                end
            end
            prev_ok = 1'b1;
        end
        prev_addr = rom_addr;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (busy !== 1'b0 || m0_rdy !== 1'b0 || m1_rdy !== 1'b0 || rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL reset_state: busy=%b m0_rdy=%b m1_rdy=%b rom_addr=%h want 0 0 0 000", busy, m0_rdy, m1_rdy, rom_addr);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || m0_rdy !== 1'b0 || m1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b m0_rdy=%b m1_rdy=%b want 0 0 0", busy, m0_rdy, m1_rdy);
        end
    endtask

    task automatic test_single();
        m0_req  = 1'b1;
        m0_addr = 11'h005;
        step();
        checks++;
        if (busy !== 1'b1 || m0_rdy !== 1'b0 || rom_addr !== 11'h005) begin
            errors++;
            $display("FAIL single_issue: busy=%b m0_rdy=%b rom_addr=%h want 1 0 005", busy, m0_rdy, rom_addr);
        end
        step();
        checks++;
        if (m0_rdy !== 1'b1 || m1_rdy !== 1'b0 || rd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_data: m0_rdy=%b m1_rdy=%b rd_data=%h want 1 0 12345678", m0_rdy, m1_rdy, rd_data);
        end
        m0_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || m0_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b m0_rdy=%b want 0 0", busy, m0_rdy);
        end
    endtask

    task automatic test_tie();
        logic exp_id;
        logic [ADDR_W-1:0] exp_addr;
        reset   = 1'b0;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        m0_addr = 11'h020;
        m1_addr = 11'h030;
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            exp_addr = exp_id ? 11'h030 : 11'h020;
            step();
            checks++;
            if (busy !== 1'b1 || m0_rdy !== 1'b0 || m1_rdy !== 1'b0 || rom_addr !== exp_addr) begin
                errors++;
                $display("FAIL tie_issue[%0d]: busy=%b rdy=%b%b rom_addr=%h want 1 00 %h", k, busy, m0_rdy, m1_rdy, rom_addr, exp_addr);
            end
            step();
            checks++;
            if (m0_rdy !== ~exp_id || m1_rdy !== exp_id || rd_data !== mem[exp_addr]) begin
                errors++;
                $display("FAIL tie_data[%0d]: m0_rdy=%b m1_rdy=%b rd_data=%h want %b %b %h", k, m0_rdy, m1_rdy, rd_data, ~exp_id, exp_id, mem[exp_addr]);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        m1_req  = 1'b1;
        m1_addr = 11'h010;
        for (int k = 0; k < 4; k++) begin
            a = 11'h010 + 11'(k);
            step();
            checks++;
            if (busy !== 1'b1 || m1_rdy !== 1'b0 || rom_addr !== a) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: busy=%b m1_rdy=%b rom_addr=%h want 1 0 %h", k, busy, m1_rdy, rom_addr, a);
            end
            step();
            checks++;
            if (busy !== 1'b1 || m1_rdy !== 1'b1 || m0_rdy !== 1'b0 || rd_data !== mem[a]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: busy=%b m1_rdy=%b m0_rdy=%b rd_data=%h want 1 1 0 %h", k, busy, m1_rdy, m0_rdy, rd_data, mem[a]);
            end
            if (k == 3) m1_req = 1'b0;
            else        m1_addr = a + 11'd1;
        end
        step();
        checks++;
        if (busy !== 1'b0 || m1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b m1_rdy=%b want 0 0", busy, m1_rdy);
        end
    endtask

    task automatic test_drop();
        int pulses;
        m0_req  = 1'b1;
        m0_addr = 11'h7FF;
        step();
        m0_req = 1'b0;
        step();
        checks++;
        if (m0_rdy !== 1'b1 || rd_data !== mem[11'h7FF]) begin
            errors++;
            $display("FAIL drop_data: m0_rdy=%b rd_data=%h want 1 %h", m0_rdy, rd_data, mem[11'h7FF]);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (m0_rdy || m1_rdy || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL drop_idle: %0d busy/rdy cycles after completion, want 0", pulses);
        end
    endtask

    task automatic test_reset_issue();
        int pulses;
        m1_req  = 1'b1;
        m1_addr = 11'h044;
        step();
        checks++;
        if (busy !== 1'b1 || rom_addr !== 11'h044) begin
            errors++;
            $display("FAIL rst_issue_setup: busy=%b rom_addr=%h want 1 044", busy, rom_addr);
        end
        m1_req = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || m0_rdy !== 1'b0 || m1_rdy !== 1'b0 || rom_addr !== 11'h000) begin
            errors++;
            $display("FAIL rst_async: busy=%b rdy=%b%b rom_addr=%h want 0 00 000", busy, m0_rdy, m1_rdy, rom_addr);
        end
        step();
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (m0_rdy || m1_rdy || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_no_pending: %0d busy/rdy cycles after release, want 0", pulses);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE_0000 ^ i;
        mem[5] = 32'h1234_5678;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_drop();
        test_reset_issue();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rom_arbiter
